// File: rtl/bridge_b0_tile_reader_if.sv
// bridge_b0_tile_reader_if: memory read ports, operand stream and control of the tile reader
interface bridge_b0_tile_reader_if #(
    parameter int W_DATA_W = 64,
    parameter int N_DATA_W = 64,
    parameter int ADDR_W_W = 3,
    parameter int ADDR_W_N = 3,
    parameter int TILE_W   = 2
);
    logic                start;
    logic                busy;
    logic                done;
    logic                w_rd_en;
    logic [ADDR_W_W-1:0] w_rd_addr;
    logic [W_DATA_W-1:0] w_rd_data;
    logic                n_rd_en;
    logic [ADDR_W_N-1:0] n_rd_addr;
    logic [N_DATA_W-1:0] n_rd_data;
    logic                out_valid;
    logic                out_ready;
    logic [W_DATA_W-1:0] out_w;
    logic [N_DATA_W-1:0] out_n;
    logic                out_first;
    logic                out_last;
    logic [TILE_W-1:0]   out_tile;

    modport master (
        input  start, w_rd_data, n_rd_data, out_ready,
        output busy, done, w_rd_en, w_rd_addr, n_rd_en, n_rd_addr,
               out_valid, out_w, out_n, out_first, out_last, out_tile
    );

    modport slave (
        output start, w_rd_data, n_rd_data, out_ready,
        input  busy, done, w_rd_en, w_rd_addr, n_rd_en, n_rd_addr,
               out_valid, out_w, out_n, out_first, out_last, out_tile
    );
endinterface

// File: rtl/bridge_b0_tile_reader.sv
// bridge_b0_tile_reader: walks west/north buffers tile by tile and streams operand pairs
module bridge_b0_tile_reader #(
    parameter int W_DATA_W  = 64,
    parameter int N_DATA_W  = 64,
    parameter int ROW_TILES = 2,
    parameter int COL_TILES = 2,
    parameter int INNER     = 4,
    parameter int ADDR_W_W  = (ROW_TILES * INNER > 1) ? $clog2(ROW_TILES * INNER) : 1,
    parameter int ADDR_W_N  = (COL_TILES * INNER > 1) ? $clog2(COL_TILES * INNER) : 1
) (
    input logic clk,
    input logic rst,
    bridge_b0_tile_reader_if.master bus
);
    localparam int TILE_W = (ROW_TILES * COL_TILES > 1) ? $clog2(ROW_TILES * COL_TILES) : 1;
    localparam int RW     = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
    localparam int CW     = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;
    localparam int KW     = (INNER > 1) ? $clog2(INNER) : 1;
    localparam int EW     = W_DATA_W + N_DATA_W + 2 + TILE_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [RW-1:0]     r;
    logic [CW-1:0]     c;
    logic [KW-1:0]     k;
    logic              busy_q;
    logic              done_q;
    logic              inflight;
    logic              p_first;
    logic              p_last;
    logic [TILE_W-1:0] p_tile;
    logic [EW-1:0]     mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        occ;
    logic              head_valid;
    logic [EW-1:0]     head;
    logic              pop;
    logic              pop_mem;
    logic              push;
    logic              issue;
    logic              k_end;
    logic              c_end;
    logic              r_end;
    logic [TILE_W-1:0] tile;

    // An empty FIFO falls through to the returning read so data reaches the multiplier the cycle it arrives
    always_comb begin
        k_end      = k == KW'(INNER - 1);
        c_end      = c == CW'(COL_TILES - 1);
        r_end      = r == RW'(ROW_TILES - 1);
        tile       = TILE_W'(r * COL_TILES + c);
        occ        = count + {1'b0, inflight};
        head_valid = count != 2'd0 || inflight;
        head       = count != 2'd0 ? mem[rd_ptr] : {bus.w_rd_data, bus.n_rd_data, p_first, p_last, p_tile};
        pop        = head_valid && bus.out_ready;
        pop_mem    = pop && count != 2'd0;
        push       = inflight && (count != 2'd0 || !pop);
        issue      = state == RUN && (occ < 2'd2 || pop);
    end

    assign bus.w_rd_en   = issue;
    assign bus.n_rd_en   = issue;
    assign bus.w_rd_addr = issue ? ADDR_W_W'(r * INNER + k) : '0;
    assign bus.n_rd_addr = issue ? ADDR_W_N'(c * INNER + k) : '0;
    assign bus.out_valid = head_valid;
    assign {bus.out_w, bus.out_n, bus.out_first, bus.out_last, bus.out_tile} = head_valid ? head : '0;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Pass sequencer: loop counters advance only on an issued beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            r      <= '0;
            c      <= '0;
            k      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state  <= RUN;
                    busy_q <= 1'b1;
                    r      <= '0;
                    c      <= '0;
                    k      <= '0;
                end
                RUN: if (issue) begin
                    k <= k_end ? '0 : k + 1'b1;
                    c <= k_end ? (c_end ? '0 : c + 1'b1) : c;
                    r <= (k_end && c_end) ? (r_end ? '0 : r + 1'b1) : r;
                    state <= (k_end && c_end && r_end) ? DRAIN : RUN;
                end
                DRAIN: if (occ == {1'b0, pop}) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency pipe for the beat sideband and FIFO occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            p_first  <= 1'b0;
            p_last   <= 1'b0;
            p_tile   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            inflight <= issue;
            if (issue) begin
                p_first <= k == '0;
                p_last  <= k_end;
                p_tile  <= tile;
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop_mem) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop_mem};
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.w_rd_data, bus.n_rd_data, p_first, p_last, p_tile};
    end
endmodule
